// File: rtl/dct_block_serializer_pkg.sv
// dct_pkg: shared constants, types and helper functions for the DCT block
// serializer slice.
//   LANE_W  width of one packed signed input lane
//   OUT_W   width of one serial signed output element
//   N       block dimension (rows per block, lanes per row)
//   lane()  extracts lane i of a packed row (lane0 is the most significant)
//   sat_s() signed LANE_W -> OUT_W clip with a clipped flag
package dct_pkg;

  localparam int LANE_W = 24;
  localparam int OUT_W  = 22;
  localparam int N      = 4;
  localparam int ROW_W  = N * LANE_W;
  localparam int K_W    = 4;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] data;
  } sat_t;

  // Lane 0 sits in the top bits of the row, lane N-1 in the bottom bits.
  function automatic logic [LANE_W-1:0] lane(input logic [ROW_W-1:0] row, input int i);
    return row[ROW_W-1-LANE_W*i -: LANE_W];
  endfunction

  // The value fits when every bit from the sign bit down to bit OUT_W-1 agrees;
  // otherwise the sign bit picks the rail.
  function automatic sat_t sat_s(input logic [LANE_W-1:0] v);
    sat_t r;
    if (v[LANE_W-1:OUT_W-1] == {(LANE_W-OUT_W+1){v[LANE_W-1]}}) begin
      r.sat  = 1'b0;
      r.data = v[OUT_W-1:0];
    end else if (v[LANE_W-1] == 1'b0) begin
      r.sat  = 1'b1;
      r.data = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      r.sat  = 1'b1;
      r.data = {1'b1, {(OUT_W-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dct_block_serializer_if.sv
// dct_block_serializer_if: row input handshake plus serial RAM write port.
//   in_valid/in_ready/in_row   packed 4-lane row input
//   out_stall                  downstream backpressure
//   out_write/out_addr/out_data/out_sat  RAM write strobe, address, element, clip flag
//   block_done                 one-cycle end-of-block pulse
// Modports: slave = serializer view, master = producer/consumer view.
interface dct_block_serializer_if;
  import dct_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             out_stall;
  logic             out_write;
  logic [K_W-1:0]   out_addr;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             block_done;

  modport slave (
    input  in_valid, in_row, out_stall,
    output in_ready, out_write, out_addr, out_data, out_sat, block_done
  );

  modport master (
    output in_valid, in_row, out_stall,
    input  in_ready, out_write, out_addr, out_data, out_sat, block_done
  );

endinterface

// File: rtl/dct_block_serializer_sat.sv
// dct_sat: combinational signed clip of one LANE_W element to OUT_W.
//   v        signed input element
//   y        clipped element
//   clipped  1 when v was outside the OUT_W signed range
module dct_sat
  import dct_pkg::*;
(
  input  logic [LANE_W-1:0] v,
  output logic [OUT_W-1:0]  y,
  output logic              clipped
);

  sat_t res_s;

  // Apply the shared clip function to the selected element
  always_comb begin
    res_s = sat_s(v);
  end

  assign y       = res_s.data;
  assign clipped = res_s.sat;

endmodule

// File: rtl/dct_block_serializer.sv
// dct_block_serializer: collects four packed rows of a 4x4 coefficient block,
// then streams the 16 saturated elements one per cycle to a RAM write port.
// TRANSPOSE=1 walks the block column-major for the second DCT pass.
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         dct_block_serializer_if.slave (row input, RAM write output)
module dct_block_serializer
  import dct_pkg::*;
#(
  parameter bit TRANSPOSE = 1'b0
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  dct_block_serializer_if.slave  bus
);

  logic [LANE_W-1:0] blk_r [N][N];
  state_t            state_r;
  logic [1:0]        row_cnt_r;
  logic [K_W-1:0]    k_r;
  logic              in_ready_r;
  logic              out_write_r;
  logic [K_W-1:0]    out_addr_r;
  logic [OUT_W-1:0]  out_data_r;
  logic              out_sat_r;
  logic              block_done_r;

  logic              row_xfer_s;
  logic              elem_xfer_s;
  logic [K_W-1:0]    sel_k_s;
  logic [1:0]        sel_row_s;
  logic [1:0]        sel_col_s;
  logic [LANE_W-1:0] elem_s;
  logic [OUT_W-1:0]  sat_data_s;
  logic              sat_flag_s;

  // Handshakes and the element to be loaded into the output registers at the next edge.
  // In FILL the next element is always k=0 (only row 0 is needed, already stored),
  // in DRAIN it is k+1; the k=15 wrap never loads, so its select value is unused.
  always_comb begin
    row_xfer_s  = (state_r == FILL) && bus.in_valid && in_ready_r;
    elem_xfer_s = (state_r == DRAIN) && out_write_r && !bus.out_stall;
    if (state_r == DRAIN) begin
      sel_k_s = k_r + 4'd1;
    end else begin
      sel_k_s = 4'd0;
    end
    if (TRANSPOSE) begin
      sel_row_s = sel_k_s[1:0];
      sel_col_s = sel_k_s[3:2];
    end else begin
      sel_row_s = sel_k_s[3:2];
      sel_col_s = sel_k_s[1:0];
    end
    elem_s = blk_r[sel_row_s][sel_col_s];
  end

  dct_sat u_sat (
    .v       (elem_s),
    .y       (sat_data_s),
    .clipped (sat_flag_s)
  );

  // Block FSM: row capture in FILL, element walk in DRAIN, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      row_cnt_r    <= 2'd0;
      k_r          <= 4'd0;
      in_ready_r   <= 1'b1;
      out_write_r  <= 1'b0;
      out_addr_r   <= 4'd0;
      out_data_r   <= {OUT_W{1'b0}};
      out_sat_r    <= 1'b0;
      block_done_r <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          blk_r[r][c] <= {LANE_W{1'b0}};
        end
      end
    end else begin
      block_done_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (row_xfer_s) begin
            for (int c = 0; c < N; c++) begin
              blk_r[row_cnt_r][c] <= lane(bus.in_row, c);
            end
            row_cnt_r <= row_cnt_r + 2'd1;
            if (row_cnt_r == 2'd3) begin
              // Last row: present element 0 on the very next cycle
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              out_write_r <= 1'b1;
              k_r         <= 4'd0;
              out_addr_r  <= 4'd0;
              out_data_r  <= sat_data_s;
              out_sat_r   <= sat_flag_s;
            end
          end
        end
        DRAIN: begin
          if (elem_xfer_s) begin
            if (k_r == 4'd15) begin
              // Block complete: reopen the input immediately, data/addr hold
              state_r      <= FILL;
              in_ready_r   <= 1'b1;
              out_write_r  <= 1'b0;
              k_r          <= 4'd0;
              row_cnt_r    <= 2'd0;
              block_done_r <= 1'b1;
            end else begin
              k_r        <= sel_k_s;
              out_addr_r <= sel_k_s;
              out_data_r <= sat_data_s;
              out_sat_r  <= sat_flag_s;
            end
          end
        end
        default: begin
          state_r     <= FILL;
          in_ready_r  <= 1'b1;
          out_write_r <= 1'b0;
          row_cnt_r   <= 2'd0;
          k_r         <= 4'd0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_write  = out_write_r;
  assign bus.out_addr   = out_addr_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_sat    = out_sat_r;
  assign bus.block_done = block_done_r;

endmodule
